snax_gemm_ctrl: RTL and testbench

CSR-programmed sequencer in front of the `snax_gemm` datapath. It accepts CSR read and write requests from the core's accelerator request channel and holds the A, B and C base addresses and the tile count. On a START write it launches the GEMM once per tile, advancing the three addresses by a fixed stride between tiles. It reports busy, done, error and cycle count back through readable CSRs.

---
 rtl/snax_gemm_ctrl.sv | 155 +++++++++++++++
 tb/tb_snax_gemm_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_gemm_ctrl.sv
// CSR-programmed tile sequencer for the snax_gemm datapath.
// It holds the base addresses and tile count, launches one GEMM per tile, and reports busy/done/err/perf through CSRs.
module snax_gemm_ctrl #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned CsrAddrWidth = 3,
  parameter int unsigned TileStride   = 512
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_write_i,
  input  logic [CsrAddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0]    req_data_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  output logic [DataWidth-1:0]    rsp_data_o,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    gemm_start_o,
  input  logic                    gemm_ready_i,
  output logic [AddrWidth-1:0]    gemm_addr_a_o,
  output logic [AddrWidth-1:0]    gemm_addr_b_o,
  output logic [AddrWidth-1:0]    gemm_addr_c_o,
  input  logic                    gemm_done_i,
  output logic                    busy_o
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait} state_e;

  localparam logic [CsrAddrWidth-1:0] CsrA      = CsrAddrWidth'(0);
  localparam logic [CsrAddrWidth-1:0] CsrB      = CsrAddrWidth'(1);
  localparam logic [CsrAddrWidth-1:0] CsrC      = CsrAddrWidth'(2);
  localparam logic [CsrAddrWidth-1:0] CsrNTiles = CsrAddrWidth'(3);
  localparam logic [CsrAddrWidth-1:0] CsrStart  = CsrAddrWidth'(4);
  localparam logic [CsrAddrWidth-1:0] CsrStatus = CsrAddrWidth'(5);
  localparam logic [CsrAddrWidth-1:0] CsrPerf   = CsrAddrWidth'(6);

  state_e                 state_q;
  logic [AddrWidth-1:0]   base_a_q, base_b_q, base_c_q;
  logic [AddrWidth-1:0]   cur_a_q, cur_b_q, cur_c_q;
  logic [15:0]            ntiles_q, tile_cnt_q;
  logic [DataWidth-1:0]   perf_q, rsp_data_q, rdata_d;
  logic                   done_q, err_q, start_q, busy_q, rsp_valid_q;
  logic                   req_acc, wr_acc, rd_acc, in_idle, busy_wr, start_wr;

  assign req_acc  = req_valid_i && !rsp_valid_q;
  assign wr_acc   = req_acc && req_write_i;
  assign rd_acc   = req_acc && !req_write_i;
  assign in_idle  = (state_q == StIdle);
  assign busy_wr  = wr_acc && !in_idle && (req_addr_i <= CsrStart);
  assign start_wr = wr_acc && (req_addr_i == CsrStart);

  // Reads return the programmed bases, never the advancing tile addresses.
  always_comb begin
    rdata_d = '0;
    case (req_addr_i)
      CsrA:      rdata_d = DataWidth'(base_a_q);
      CsrB:      rdata_d = DataWidth'(base_b_q);
      CsrC:      rdata_d = DataWidth'(base_c_q);
      CsrNTiles: rdata_d = DataWidth'(ntiles_q);
      CsrStatus: rdata_d = DataWidth'({err_q, done_q, busy_q});
      CsrPerf:   rdata_d = perf_q;
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      base_a_q    <= '0;
      base_b_q    <= '0;
      base_c_q    <= '0;
      cur_a_q     <= '0;
      cur_b_q     <= '0;
      cur_c_q     <= '0;
      ntiles_q    <= '0;
      tile_cnt_q  <= '0;
      perf_q      <= '0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (rsp_valid_q && rsp_ready_i) rsp_valid_q <= 1'b0;
      if (rd_acc) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= rdata_d;
      end
      if (busy_wr) err_q <= 1'b1;
      if (wr_acc && in_idle) begin
        case (req_addr_i)
          CsrA:      base_a_q <= AddrWidth'(req_data_i);
          CsrB:      base_b_q <= AddrWidth'(req_data_i);
          CsrC:      base_c_q <= AddrWidth'(req_data_i);
          CsrNTiles: ntiles_q <= req_data_i[15:0];
          default: ;
        endcase
      end
      if (wr_acc && req_addr_i == CsrStatus) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (!in_idle && perf_q != '1) perf_q <= perf_q + DataWidth'(1);
      // FSM updates come last so a completing run's done wins over a same-cycle STATUS clear.
      case (state_q)
        StIdle: if (start_wr) begin
          if (ntiles_q == '0) begin
            done_q <= 1'b1;
          end else begin
            cur_a_q    <= base_a_q;
            cur_b_q    <= base_b_q;
            cur_c_q    <= base_c_q;
            tile_cnt_q <= '0;
            perf_q     <= '0;
            done_q     <= 1'b0;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StLaunch;
          end
        end
        StLaunch: if (gemm_ready_i) begin
          start_q <= 1'b0;
          state_q <= StWait;
        end
        StWait: if (gemm_done_i) begin
          tile_cnt_q <= tile_cnt_q + 16'd1;
          if (tile_cnt_q + 16'd1 == ntiles_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            cur_a_q <= cur_a_q + AddrWidth'(TileStride);
            cur_b_q <= cur_b_q + AddrWidth'(TileStride);
            cur_c_q <= cur_c_q + AddrWidth'(TileStride);
            start_q <= 1'b1;
            state_q <= StLaunch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o   = !rsp_valid_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign gemm_start_o  = start_q;
  assign gemm_addr_a_o = cur_a_q;
  assign gemm_addr_b_o = cur_b_q;
  assign gemm_addr_c_o = cur_c_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_snax_gemm_ctrl.sv
// Self-checking bench for snax_gemm_ctrl: a run-level reference model compared every cycle, directed scenarios, and random CSR traffic.
module tb_snax_gemm_ctrl;
  localparam int STRIDE = 512;

  logic        clk = 1'b0;
  logic        rst_i, req_write_i, req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [2:0]  req_addr_i;
  logic [31:0] req_data_i, rsp_data_o;
  logic        gemm_start_o, gemm_ready_i, gemm_done_i, busy_o;
  logic [31:0] gemm_addr_a_o, gemm_addr_b_o, gemm_addr_c_o;

  always #5 clk = ~clk;

  snax_gemm_ctrl #(.DataWidth(32), .AddrWidth(32), .CsrAddrWidth(3), .TileStride(STRIDE)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .gemm_start_o(gemm_start_o), .gemm_ready_i(gemm_ready_i),
    .gemm_addr_a_o(gemm_addr_a_o), .gemm_addr_b_o(gemm_addr_b_o), .gemm_addr_c_o(gemm_addr_c_o),
    .gemm_done_i(gemm_done_i), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Reference model: run-level view; tile address = base + index*stride, perf = cycles since START.
  logic [31:0] m_base[3], m_run[3];
  logic [15:0] m_nt;
  bit          m_running, m_launch, m_done, m_err, m_rv;
  logic [31:0] m_rd, m_perf;
  int          m_k;
  longint      cyc = 0, m_t0;

  task automatic model_reset();
    m_base = '{default: 32'h0};
    m_run  = '{default: 32'h0};
    m_nt = '0; m_running = 0; m_launch = 0; m_done = 0; m_err = 0; m_rv = 0;
    m_rd = '0; m_perf = '0; m_k = 0; m_t0 = 0;
  endtask

  function automatic logic [31:0] m_read(input int a);
    case (a)
      0, 1, 2: return m_base[a];
      3:       return {16'h0, m_nt};
      5:       return {29'h0, m_err, m_done, m_running};
      6:       return m_perf;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_addr(input int i);
    return m_run[i] + m_k * STRIDE;
  endfunction

  task automatic model_step();
    bit was_run, acc;
    logic [31:0] rd;
    cyc++;
    if (rst_i) begin
      model_reset();
      return;
    end
    was_run = m_running;
    acc = req_valid_i && !m_rv;
    rd = m_read(int'(req_addr_i));
    if (m_rv && rsp_ready_i) m_rv = 0;
    if (acc && !req_write_i) begin
      m_rv = 1;
      m_rd = rd;
    end
    if (was_run) m_perf = (cyc - m_t0 > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(cyc - m_t0);
    if (acc && req_write_i) begin
      if (was_run && req_addr_i <= 3'd4) m_err = 1;
      else case (req_addr_i)
        3'd0, 3'd1, 3'd2: m_base[req_addr_i] = req_data_i;
        3'd3: m_nt = req_data_i[15:0];
        3'd4: if (m_nt == 0) m_done = 1;
              else begin
                m_running = 1; m_launch = 1; m_k = 0; m_run = m_base;
                m_perf = 0; m_t0 = cyc; m_done = 0;
              end
        3'd5: begin m_done = 0; m_err = 0; end
        default: ;
      endcase
    end
    if (was_run) begin
      if (m_launch) begin
        if (gemm_ready_i) m_launch = 0;
      end else if (gemm_done_i) begin
        if (m_k + 1 == int'(m_nt)) begin m_running = 0; m_done = 1; end
        else begin m_k++; m_launch = 1; end
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("req_ready", req_ready_o, !m_rv);
      chk("rsp_valid", rsp_valid_o, m_rv);
      if (m_rv) chk("rsp_data", rsp_data_o, m_rd);
      chk("gemm_start", gemm_start_o, m_running && m_launch);
      chk("busy", busy_o, m_running);
      chk("addr_a", gemm_addr_a_o, m_addr(0));
      chk("addr_b", gemm_addr_b_o, m_addr(1));
      chk("addr_c", gemm_addr_c_o, m_addr(2));
    end
  end

  // GEMM responder: directed mode pulses done 5 cycles after each launch; random mode is free-running.
  int mode = 0, ready_hold = 0, lowcnt = 0, dcnt = -1;
  bit hs_pend = 0;
  logic [31:0] qa[$], qb[$], qc[$];

  initial begin
    gemm_ready_i = 0;
    gemm_done_i  = 0;
    forever begin
      @(negedge clk);
      gemm_done_i = 0;
      if (hs_pend) dcnt = 4;
      else if (dcnt > 0) dcnt--;
      if (mode == 0) begin
        if (dcnt == 0) begin gemm_done_i = 1; dcnt = -1; end
        if (gemm_start_o && ready_hold > 0) begin
          gemm_ready_i = 0; ready_hold--; lowcnt++;
        end else gemm_ready_i = 1;
      end else begin
        gemm_done_i  = ($urandom_range(0, 3) == 0);
        gemm_ready_i = ($urandom_range(0, 2) != 0);
      end
      hs_pend = gemm_start_o && gemm_ready_i;
      if (hs_pend) begin
        qa.push_back(gemm_addr_a_o);
        qb.push_back(gemm_addr_b_o);
        qc.push_back(gemm_addr_c_o);
      end
    end
  end

  task automatic csr(input bit wr, input int a, input logic [31:0] d, input int rdelay,
                     output logic [31:0] rdata);
    int n;
    rdata = '0;
    @(negedge clk);
    n = 0;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    if (!req_ready_o) begin timeout_fail("req_ready_wait"); return; end
    req_valid_i = 1; req_write_i = wr; req_addr_i = a[2:0]; req_data_i = d;
    @(negedge clk);
    req_valid_i = 0;
    if (!wr) begin
      n = 0;
      while (!rsp_valid_o && n < 20) begin @(negedge clk); n++; end
      if (!rsp_valid_o) begin timeout_fail("rsp_valid_wait"); return; end
      rdata = rsp_data_o;
      for (int i = 0; i < rdelay; i++) begin
        rsp_ready_i = 0;
        @(negedge clk);
        chk("rsp_hold_data", rsp_data_o, rdata);
        chk("rsp_hold_req_ready", req_ready_o, 0);
      end
      rsp_ready_i = 1;
      @(negedge clk);
    end
  endtask

  task automatic wr_csr(input int a, input logic [31:0] d);
    logic [31:0] dummy;
    csr(1'b1, a, d, 0, dummy);
  endtask

  task automatic rd_csr(input int a, input int rdelay, output logic [31:0] v);
    csr(1'b0, a, 32'h0, rdelay, v);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy_o && n < budget) begin @(negedge clk); n++; end
    if (busy_o) timeout_fail("wait_idle");
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qc.delete();
  endtask

  logic [31:0] expA[3] = '{32'h80,  32'h280, 32'h480};
  logic [31:0] expB[3] = '{32'h280, 32'h480, 32'h680};
  logic [31:0] expC[3] = '{32'h480, 32'h680, 32'h880};

  task automatic check_three_tiles(input string tag);
    chk({tag, "_launches"}, qa.size(), 3);
    if (qa.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk({tag, "_tileA"}, qa[i], expA[i]);
        chk({tag, "_tileB"}, qb[i], expB[i]);
        chk({tag, "_tileC"}, qc[i], expC[i]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] v;
  int op, n;

  initial begin
    rst_i = 1; req_valid_i = 0; req_write_i = 0; req_addr_i = '0; req_data_i = '0; rsp_ready_i = 1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_gemm_start", gemm_start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr_a", gemm_addr_a_o, 0);
    rst_i = 0;

    // Zero tiles straight out of reset.
    clear_q();
    wr_csr(3, 32'h0);
    wr_csr(4, 32'h1);
    repeat (3) @(negedge clk);
    chk("zero_busy", busy_o, 0);
    chk("zero_launches", qa.size(), 0);
    rd_csr(5, 0, v); chk("zero_status", v, 32'h2);
    rd_csr(6, 0, v); chk("zero_perf", v, 32'h0);

    // Three-tile run.
    wr_csr(0, 32'h80); wr_csr(1, 32'h280); wr_csr(2, 32'h480);
    wr_csr(3, 32'hABCD_0003);
    rd_csr(3, 0, v); chk("ntiles_readback", v, 32'h3);
    clear_q();
    wr_csr(4, 32'h0);
    wait_idle(200);
    check_three_tiles("run3");
    rd_csr(5, 0, v); chk("run3_status", v, 32'h2);
    chk("run3_busy", busy_o, 0);

    // Backpressure on both launch and response channels.
    wr_csr(3, 32'h1);
    lowcnt = 0; ready_hold = 4;
    wr_csr(4, 32'h0);
    rd_csr(5, 3, v); chk("bp_status", v, 32'h1);
    wait_idle(200);
    chk("bp_start_held", lowcnt, 4);

    // Write while busy is dropped and flagged.
    wr_csr(3, 32'h3);
    clear_q();
    wr_csr(4, 32'h0);
    repeat (2) @(negedge clk);
    wr_csr(0, 32'h1000);
    rd_csr(0, 0, v); chk("busy_addr_a", v, 32'h80);
    rd_csr(5, 0, v); chk("busy_status", v, 32'h5);
    wait_idle(200);
    check_three_tiles("busywr");
    wr_csr(5, 32'h0);
    rd_csr(5, 0, v); chk("status_cleared", v, 32'h0);

    // Address wrap and cycle count: launch t+1, done t+6, relaunch t+7, done t+12.
    wr_csr(0, 32'hFFFF_FF00); wr_csr(3, 32'h2);
    clear_q();
    wr_csr(4, 32'h0);
    wait_idle(200);
    chk("wrap_launches", qa.size(), 2);
    if (qa.size() == 2) begin
      chk("wrap_a0", qa[0], 32'hFFFF_FF00);
      chk("wrap_a1", qa[1], 32'h0000_0100);
    end
    rd_csr(6, 0, v); chk("wrap_perf", v, 32'd12);

    // Reset while waiting for a tile; the responder's pending done then arrives as a stray pulse.
    wr_csr(3, 32'h3);
    wr_csr(4, 32'h0);
    n = 0;
    while (!(busy_o && !gemm_start_o) && n < 50) begin @(negedge clk); n++; end
    if (!(busy_o && !gemm_start_o)) timeout_fail("reach_wait");
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    chk("rstw_busy", busy_o, 0);
    chk("rstw_start", gemm_start_o, 0);
    chk("rstw_req_ready", req_ready_o, 1);
    chk("rstw_rsp_valid", rsp_valid_o, 0);
    chk("rstw_addr_a", gemm_addr_a_o, 0);
    chk("rstw_addr_c", gemm_addr_c_o, 0);
    clear_q();
    repeat (8) @(negedge clk);
    chk("rstw_stray_busy", busy_o, 0);
    chk("rstw_stray_launches", qa.size(), 0);
    rd_csr(5, 0, v); chk("rstw_status", v, 32'h0);
    rd_csr(0, 0, v); chk("rstw_base_a", v, 32'h0);

    // Random CSR traffic against a free-running GEMM.
    mode = 1;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1: rd_csr($urandom_range(0, 7), $urandom_range(0, 2), v);
        2, 3: wr_csr($urandom_range(0, 2), $urandom);
        4:    wr_csr(3, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 4));
        5, 6: wr_csr(4, $urandom);
        7:    wr_csr(5, $urandom);
        8:    wr_csr($urandom_range(6, 7), $urandom);
        default: repeat ($urandom_range(1, 6)) @(negedge clk);
      endcase
      if (it == 150) begin
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
      end
    end
    wait_idle(2000);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
